// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
//   Round-robin arbiter that shares one WIDTH:1 bit-select datapath among
//   WIDTH requesters. The arbiter registers a one-hot grant and the owner
//   index s, so y = i[s] while a grant is active. Each ownership is capped at
//   MAX_BEATS consecutive cycles. When the cap is reached the owner is
//   force-released, and tout pulses for one cycle.
//
//   Optional macro MUX_ARB_FIXED_PRIO_EN: when it is defined, the winner is
//   always the lowest-index requester. The last-owner pointer is still kept
//   up to date. When it is undefined, the search starts at last+1 and wraps.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   req    : request vector, bit k = requester k wants the line
//   i      : data bits, bit k belongs to requester k
//   s      : registered select (index of current owner)
//   gnt    : registered one-hot grant, zero when idle
//   valid  : registered, 1 while a grant is active
//   y      : combinational i[s] when valid, else 0
//   tout   : registered one-cycle pulse on a forced release
module mux_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BEATS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         req,
  input  logic [WIDTH-1:0]         i,
  output logic [$clog2(WIDTH)-1:0] s,
  output logic [WIDTH-1:0]         gnt,
  output logic                     valid,
  output logic                     y,
  output logic                     tout
);

  localparam int          SW = $clog2(WIDTH);
  localparam int          CW = $clog2(MAX_BEATS + 1);
  localparam int unsigned N  = WIDTH;
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_BEATS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SW-1:0] LAST_RST = SW'(WIDTH - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SW-1:0]   last;

  logic [SW-1:0]   win;
  logic [WIDTH-1:0] win_oh;
  logic            any_req;
  logic            owner_req;
  logic            at_max;
  logic            rel;
  logic            forced;

  assign any_req   = |req;
  assign owner_req = req[s];
  assign at_max    = (cnt == CNT_MAX);
  // Dropping the request in the same cycle as the cap counts as voluntary.
  assign rel       = !owner_req || at_max;
  assign forced    = owner_req && at_max;

  // Winner search.
  // Round-robin: scan offsets 1..WIDTH from last. Offset WIDTH lands back on
  // last, so a sole requester that was forced out is granted again.
  always_comb begin
    logic        found;
    int unsigned idx;
    win    = '0;
    win_oh = '0;
    found  = 1'b0;
    idx    = 0;
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && req[SW'(k)]) begin
        found = 1'b1;
        win   = SW'(k);
      end
    end
`else
    for (int unsigned off = 1; off <= N; off++) begin
      idx = 32'(last) + off;
      if (idx >= N) idx = idx - N;
      if (!found && req[SW'(idx)]) begin
        found = 1'b1;
        win   = SW'(idx);
      end
    end
`endif
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      s     <= '0;
      gnt   <= '0;
      valid <= 1'b0;
      tout  <= 1'b0;
      cnt   <= '0;
      last  <= LAST_RST;
    end else begin
      case (state)
        IDLE: begin
          tout <= 1'b0;
          if (any_req) begin
            state <= GRANT;
            s     <= win;
            gnt   <= win_oh;
            valid <= 1'b1;
            cnt   <= CNT_ONE;
            last  <= win;
          end
        end
        GRANT: begin
          if (rel) begin
            tout <= forced;
            if (any_req) begin
              // Handover with no bubble: valid stays high.
              s    <= win;
              gnt  <= win_oh;
              cnt  <= CNT_ONE;
              last <= win;
            end else begin
              state <= IDLE;
              gnt   <= '0;
              valid <= 1'b0;
            end
          end else begin
            tout <= 1'b0;
            cnt  <= cnt + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign y = valid & i[s];

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter
//   Scoreboard bench for mux_rr_arbiter (WIDTH=4, MAX_BEATS=4). For each
//   drive, a behavioural model pushes the expected outputs into a queue. The
//   entry is popped and compared after the next rising edge.
module tb_mux_rr_arbiter;

  localparam int W  = 4;
  localparam int MB = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  req = '0;
  logic [W-1:0]  i = '0;
  logic [SW-1:0] s;
  logic [W-1:0]  gnt;
  logic          valid;
  logic          y;
  logic          tout;

  mux_rr_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .i     (i),
    .s     (s),
    .gnt   (gnt),
    .valid (valid),
    .y     (y),
    .tout  (tout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [W-1:0]  gnt;
    logic [SW-1:0] s;
    logic          valid;
    logic          tout;
    logic          y;
  } exp_t;

  exp_t sb[$];

  // Reference model state.
  logic [SW-1:0] m_s;
  logic [SW-1:0] m_last;
  int            m_cnt;
  logic          m_valid;
  logic          m_tout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s     = '0;
    m_last  = SW'(W - 1);
    m_cnt   = 0;
    m_valid = 1'b0;
    m_tout  = 1'b0;
  endtask

  function automatic logic [SW-1:0] pick(input logic [W-1:0] r);
    logic [SW-1:0] p;
    p = '0;
`ifdef MUX_ARB_FIXED_PRIO_EN
    for (int k = W - 1; k >= 0; k--)
      if (r[k]) p = SW'(k);
`else
    // Scan from the farthest offset down, so the nearest one after last wins.
    for (int k = W; k >= 1; k--)
      if (r[(int'(m_last) + k) % W]) p = SW'((int'(m_last) + k) % W);
`endif
    return p;
  endfunction

  task automatic model_load(input logic [W-1:0] r);
    logic [SW-1:0] w;
    w       = pick(r);
    m_s     = w;
    m_last  = w;
    m_cnt   = 1;
    m_valid = 1'b1;
  endtask

  task automatic drive(input logic [W-1:0] r, input logic [W-1:0] d);
    exp_t e;
    exp_t g;
    logic own;
    @(negedge clk);
    req = r;
    i   = d;
    if (!m_valid) begin
      m_tout = 1'b0;
      if (r != '0) model_load(r);
    end else begin
      own = r[m_s];
      if (!own || m_cnt == MB) begin
        m_tout = own;
        if (r != '0) model_load(r);
        else m_valid = 1'b0;
      end else begin
        m_cnt++;
        m_tout = 1'b0;
      end
    end
    e.gnt   = m_valid ? (W'(1) << m_s) : '0;
    e.s     = m_s;
    e.valid = m_valid;
    e.tout  = m_tout;
    e.y     = m_valid & d[m_s];
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      g = sb.pop_front();
      check("gnt",   32'(gnt),   32'(g.gnt));
      check("s",     32'(s),     32'(g.s));
      check("valid", 32'(valid), 32'(g.valid));
      check("tout",  32'(tout),  32'(g.tout));
      check("y",     32'(y),     32'(g.y));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",   32'(gnt),   32'd0);
    check("rst_s",     32'(s),     32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_tout",  32'(tout),  32'd0);
    check("rst_y",     32'(y),     32'd0);
    rst_n = 1'b1;

    // Assert reset in the middle of a grant; outputs must clear at once.
    for (int k = 0; k < 6; k++) drive(4'b1111, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt",   32'(gnt),   32'd0);
    check("async_s",     32'(s),     32'd0);
    check("async_valid", 32'(valid), 32'd0);
    check("async_tout",  32'(tout),  32'd0);
    check("async_y",     32'(y),     32'd0);
    model_reset();
    rst_n = 1'b1;
    drive(4'b1111, 4'b0001);
    check("first_gnt", 32'(gnt), 32'b0001);
    drive(4'b0000, 4'b0000);
    drive(4'b0000, 4'b1111);

    // Single requester: forced releases re-grant without a valid gap.
    for (int k = 0; k < 10; k++) drive(4'b0100, 4'b0100);
    drive(4'b0000, 4'b0100);

    // Full rotation.
    for (int k = 0; k < 20; k++) drive(4'b1111, W'($urandom));
    drive(4'b0000, 4'b0000);

    // Voluntary release, then a lone requester 0.
    drive(4'b0010, 4'b0010);
    drive(4'b0010, 4'b0010);
    drive(4'b1001, 4'b1001);
    for (int k = 0; k < 6; k++) drive(4'b0001, 4'b0001);
    drive(4'b0000, 4'b0000);

    // Owner drops its request in the cycle the cap is reached.
    drive(4'b0100, 4'b0100);
    for (int k = 0; k < 8 && m_cnt != MB; k++) drive(4'b0100, 4'b0100);
    drive(4'b0000, 4'b1111);
    check("simul_tout_idle", 32'(tout), 32'd0);
    drive(4'b0100, 4'b0100);
    for (int k = 0; k < 8 && m_cnt != MB; k++) drive(4'b0100, 4'b0100);
    drive(4'b0001, 4'b0001);
    check("simul_tout_next", 32'(tout), 32'd0);
    drive(4'b0000, 4'b0000);

    // Two requesters held: rotation (or fixed priority when enabled).
    for (int k = 0; k < 14; k++) drive(4'b1010, 4'b1010);
    for (int k = 0; k < 4; k++) drive(4'b1000, 4'b1000);
    drive(4'b0000, 4'b0000);

    // Random traffic.
    for (int k = 0; k < 300; k++) drive(W'($urandom), W'($urandom));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
